fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RV32 CPU. It replaces the bare PC register and IF/ID latch with four pieces:
- a PC generator;
- an instruction-memory request/response interface that allows several requests in flight;
- a prefetch queue of QUEUE_DEPTH entries;
- redirect/flush handling for branches and jumps.

It sits between instruction memory and the ID stage. It hands {pc, instr} pairs to decode with a valid/ready handshake.

---
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage for the pipelined RV32 core. It generates fetch
// addresses, keeps several instruction-memory requests in flight, buffers
// the returned words in a small prefetch queue, and hands {pc, instr} pairs
// to decode with a valid/ready handshake. A redirect (taken branch, jump or
// flush) empties the queue, cancels every response still in flight and
// restarts fetching at the new address.
//
// Ports
//    clk             - clock, rising edge
//    reset           - asynchronous reset, active low
//    imem_req_valid  - fetch request valid
//    imem_req_ready  - memory accepts the request this cycle
//    imem_req_addr   - word-aligned fetch address
//    imem_resp_valid - response valid (responses return in request order)
//    imem_resp_data  - instruction word of the response
//    redirect_valid  - redirect fetch to redirect_pc this cycle
//    redirect_pc     - new fetch address (bits [1:0] are ignored)
//    if_valid        - queue head valid towards decode
//    if_ready        - decode consumes the head this cycle
//    if_pc           - PC of the head entry (0 when the queue is empty)
//    if_instr        - instruction of the head entry (0 when empty)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                XLEN        = 32,
   parameter logic [XLEN-1:0]   RESET_PC    = {XLEN{1'b0}},
   parameter int                QUEUE_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_resp_valid,
   input  logic [XLEN-1:0]  imem_resp_data,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [XLEN-1:0]  if_pc,
   output logic [XLEN-1:0]  if_instr
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int PW = $clog2(QUEUE_DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] tag_pc;
   logic [CW-1:0]   occupancy;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;

   logic [XLEN-1:0] pc_store    [QUEUE_DEPTH];
   logic [XLEN-1:0] instr_store [QUEUE_DEPTH];

   logic [CW:0]     in_use;
   logic            credit_ok;
   logic            req_fire;
   logic            drop_active;
   logic            resp_push;
   logic            pop;
   logic [XLEN-1:0] redirect_aligned;
   logic            unused_redirect_bits;

   // Request credit: a request may only go out if a queue slot is already
   // reserved for its response, counting both buffered entries and requests
   // still in flight. This is what makes queue overflow impossible.
   always_comb begin
      in_use           = {1'b0, occupancy} + {1'b0, outstanding};
      credit_ok        = (in_use < (CW+1)'(QUEUE_DEPTH));
      imem_req_valid   = reset & ~redirect_valid & credit_ok;
      imem_req_addr    = fetch_pc;
      req_fire         = imem_req_valid & imem_req_ready;
      drop_active      = (drop != '0);
      resp_push        = imem_resp_valid & ~drop_active & ~redirect_valid;
      pop              = if_valid & if_ready;
      redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
   end

   assign unused_redirect_bits = ^redirect_pc[1:0];

   // Head of the queue towards decode; the data outputs read zero while the
   // queue is empty so decode never sees stale words.
   always_comb begin
      if_valid = (occupancy != '0);
      if_pc    = '0;
      if_instr = '0;
      if (if_valid) begin
         if_pc    = pc_store[head];
         if_instr = instr_store[head];
      end
   end

   // Fetch address: jumps to the (word-aligned) redirect target, otherwise
   // advances by one word every time memory accepts a request. Wraps
   // naturally at 2^XLEN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_aligned;
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + XLEN'(4);
      end
   end

   // PC tag for the next response that will actually be queued. Because
   // responses come back in order and cancelled ones are filtered out by the
   // drop counter, the next kept response always belongs to this address,
   // so a single register replaces a per-request PC FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_pc <= RESET_PC;
      end else if (redirect_valid) begin
         tag_pc <= redirect_aligned;
      end else if (resp_push) begin
         tag_pc <= tag_pc + XLEN'(4);
      end
   end

   // In-flight bookkeeping. On a redirect every live request becomes one to
   // be discarded; a response arriving in the redirect cycle is itself
   // discarded, so it is taken off the total straight away.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect_valid) begin
         outstanding <= '0;
         drop        <= drop + outstanding - CW'(imem_resp_valid);
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_push);
         if (imem_resp_valid && drop_active) begin
            drop <= drop - CW'(1);
         end
      end
   end

   // Queue pointers and occupancy. Push and pop in the same cycle leave the
   // occupancy unchanged even when the queue is full, because the credit
   // scheme guarantees the pushed entry already owns a slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else if (redirect_valid) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (resp_push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         occupancy <= occupancy + CW'(resp_push) - CW'(pop);
      end
   end

   // Queue storage. No reset needed: an entry is only ever read after it
   // has been written, since the outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (resp_push) begin
         pc_store[tail]    <= tag_pc;
         instr_store[tail] <= imem_resp_data;
      end
   end

   // A response with nothing in flight means the memory model is broken.
   assert property (@(posedge clk) disable iff (!reset)
      imem_resp_valid |-> ((outstanding != '0) || (drop != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Testbench for fetch_unit. A behavioural instruction memory answers every
// accepted request in order after a chosen latency. A reference model keeps
// the expected decode queue as a list of PCs, tags every in-flight request
// with a redirect epoch (anything from an older epoch, or arriving during a
// redirect, is cancelled), and predicts the request handshake and queue-head
// outputs every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_resp_valid;
   logic [XLEN-1:0]   imem_resp_data;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              if_valid;
   logic              if_ready;
   logic [XLEN-1:0]   if_pc;
   logic [XLEN-1:0]   if_instr;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } mem_req_t;

   mem_req_t    pending[$];
   logic [31:0] model_q[$];
   logic [31:0] model_fetch_pc;
   int          epoch;
   int          cycle;
   int          last_due;
   int          lat;
   int          total;
   int          bad;

   fetch_unit #(
      .XLEN        (XLEN),
      .RESET_PC    (RESET_PC),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Contents of instruction memory: a scrambled function of the address so
   // that every word is distinct and tied to its PC.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
   endfunction

   // Number of requests in flight that still belong to the current epoch.
   function automatic int liveInFlight();
      int n = 0;
      foreach (pending[i]) begin
         if (pending[i].epoch == epoch) n++;
      end
      return n;
   endfunction

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)",
                tag, observed, expected, cycle);
      end
   endtask

   // One clock cycle: entered just after a rising edge, drives the inputs,
   // checks the settled outputs before the next edge, then advances the
   // reference model across that edge.
   task automatic applyStimulus(input logic mem_rdy, input logic id_rdy,
                                input logic redir, input logic [31:0] rpc);
      logic        resp_now;
      logic        exp_req_valid;
      logic        exp_if_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      mem_req_t    head_req;
      int          due;

      resp_now = (pending.size() != 0) && (pending[0].due <= cycle);
      imem_req_ready  = mem_rdy;
      if_ready        = id_rdy;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      imem_resp_valid = resp_now;
      imem_resp_data  = resp_now ? memWord(pending[0].addr) : $urandom();

      exp_req_valid = !redir && ((model_q.size() + liveInFlight()) < DEPTH);
      exp_if_valid  = (model_q.size() != 0);
      exp_pc        = 32'h0;
      exp_instr     = 32'h0;
      if (exp_if_valid) begin
         exp_pc    = model_q[0];
         exp_instr = memWord(model_q[0]);
      end

      #3;
      checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
      checkOutput("req_addr",  imem_req_addr, model_fetch_pc);
      checkOutput("if_valid",  32'(if_valid), 32'(exp_if_valid));
      checkOutput("if_pc",     if_pc, exp_pc);
      checkOutput("if_instr",  if_instr, exp_instr);

      @(posedge clk);
      head_req = '{32'h0, 0, -1};
      if (resp_now) head_req = pending.pop_front();
      if (exp_if_valid && id_rdy && !redir) void'(model_q.pop_front());
      if (resp_now && !redir && head_req.epoch == epoch) begin
         model_q.push_back(head_req.addr);
      end
      if (exp_req_valid && mem_rdy) begin
         due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
         pending.push_back('{model_fetch_pc, due, epoch});
         last_due = due;
         model_fetch_pc = model_fetch_pc + 32'd4;
      end
      if (redir) begin
         model_q.delete();
         epoch++;
         model_fetch_pc = {rpc[31:2], 2'b00};
      end
      cycle++;
      #1;
   endtask

   // Asynchronous reset in the middle of a cycle: the outputs must drop
   // before any clock edge. Memory forgets its in-flight requests.
   task automatic pullReset(input int hold_cycles);
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      imem_req_ready  = 1'b1;
      if_ready        = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst_if_valid",  32'(if_valid), 32'd0);
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_if_pc",     if_pc, 32'd0);
      checkOutput("rst_if_instr",  if_instr, 32'd0);
      pending.delete();
      model_q.delete();
      epoch++;
      model_fetch_pc = RESET_PC;
      repeat (hold_cycles) @(posedge clk);
      cycle    = cycle + hold_cycles;
      last_due = cycle;
      #1;
      checkOutput("rst_hold_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_hold_addr",      imem_req_addr, RESET_PC);
      reset = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      epoch = 0;
      cycle = 0;
      last_due = 0;
      lat   = 1;
      model_fetch_pc  = RESET_PC;
      reset           = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      if_ready        = 1'b0;

      // Held in reset across a couple of edges.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("init_if_valid",  32'(if_valid), 32'd0);
      checkOutput("init_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("init_if_pc",     if_pc, 32'd0);
      checkOutput("init_if_instr",  if_instr, 32'd0);
      checkOutput("init_addr",      imem_req_addr, RESET_PC);
      reset = 1'b1;

      // Streaming with a 1-cycle memory and decode always ready.
      lat = 1;
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Decode stalled: queue fills and requests stop; then drains in order.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
      repeat (8)  applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // 3-cycle memory, two requests in flight, then redirect to 0x100.
      lat = 3;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
      repeat (2)  applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect coinciding with a response and a pop; target is misaligned.
      lat = 1;
      repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400 | ($urandom() & 32'h0000_0FF0) | 32'h3);
      repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Memory not ready for 5 cycles with the address parked at 0x8.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Fill 3 entries with decode stalled, then reset mid-stream.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0800);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      pullReset(2);
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Randomised traffic: latency, both ready signals and redirects.
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) lat = $urandom_range(1, 3);
         applyStimulus(($urandom() % 4) != 0, ($urandom() % 3) != 0,
                       ($urandom() % 20) == 0, $urandom());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
